// File: rtl/rtc_div_pkg.sv
// Shared constants and helpers for the RTC multi-channel clock divider.
// Latency: n/a (package); backpressure: n/a.
package rtc_div_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    function automatic longint unsigned half_from_hz(input longint unsigned sys_hz,
                                                     input longint unsigned hz);
        return sys_hz / (2 * hz);
    endfunction

endpackage

// File: rtl/rtc_div_chan.sv
// One divider channel: counter, live and pending half-period, square wave and rise tick.
// Latency: outputs registered, 1 cycle; backpressure: pending blocks a new write until applied.
module rtc_div_chan
    import rtc_div_pkg::*;
#(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(1)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_req,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_val;
    logic             wrap;

    // half_q is never 0, so cnt always stays within [0, half_q-1]
    assign wrap = (cnt == half_q - CNT_W'(1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            half_q   <= DEF_HALF;
            pend_val <= '0;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync_req) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                if (pending) begin
                    half_q  <= pend_val;
                    pending <= 1'b0;
                end
            end else if (en) begin
                if (wrap) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= ~clk_out;
                    if (pending) begin
                        half_q  <= pend_val;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (pending) begin
                // idle channel: take the new period now and restart the half-period
                half_q  <= pend_val;
                pending <= 1'b0;
                cnt     <= '0;
            end
            // a write is only accepted while nothing is pending, so this never races the clear above
            if (cfg_wr) begin
                pend_val <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_multi_clk_div.sv
// N-channel RTC clock divider with valid/ready half-period reprogramming; RTC_DIV_PHASE_SYNC_EN adds sync_req.
// Latency: outputs registered, cfg_err 1 cycle after accept; backpressure: cfg_ready low while target channel has a pending write.
module rtc_multi_clk_div
    import rtc_div_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int CNT_W            = 32,
    parameter int SYS_CLK_HZ       = 1_000_000,
    parameter int KEYCHANGE_PERIOD = 5,
    parameter int CH0_HZ           = 500
) (
`ifdef RTC_DIV_PHASE_SYNC_EN
    input  logic                sync_req,
`endif
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_chan,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick
);

    localparam longint unsigned H0_L  = half_from_hz(64'(SYS_CLK_HZ), 64'(CH0_HZ));
    localparam longint unsigned HK_L  = 64'(KEYCHANGE_PERIOD) * 64'(SYS_CLK_HZ) / 64'd2;
    localparam longint unsigned LIM_L = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] H0   = CNT_W'(H0_L);
    localparam logic [CNT_W-1:0] HK   = CNT_W'(HK_L);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end
    if (H0_L == 0 || H0_L > LIM_L || (NUM_CH > 1 && (HK_L == 0 || HK_L > LIM_L))) begin : g_bad_half
        $error("default half-period does not fit CNT_W");
    end

    logic                sync_int;
    logic [NUM_CH-1:0]   pending;
    logic [MAX_CH-1:0]   pend_ext;
    logic                bad_chan;
    logic                accept;

`ifdef RTC_DIV_PHASE_SYNC_EN
    assign sync_int = sync_req;
`else
    assign sync_int = 1'b0;
`endif

    // widen to the full index range so out-of-range channels read as not pending
    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pending;
    end

    assign bad_chan  = ({1'b0, cfg_chan} >= 4'(NUM_CH));
    assign cfg_ready = bad_chan | ~pend_ext[cfg_chan];
    assign accept    = cfg_valid & cfg_ready;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & bad_chan;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_IDX_W-1:0] IDX = CH_IDX_W'(i);
        logic chan_wr;

        assign chan_wr = accept & ~bad_chan & (cfg_chan == IDX);

        rtc_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF ((i == 0) ? H0 : HK)
        ) u_chan (
            .sys_clk  (sys_clk),
            .rst      (rst),
            .en       (en[i]),
            .sync_req (sync_int),
            .cfg_wr   (chan_wr),
            .cfg_half (cfg_half),
            .pending  (pending[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule
